lsu_rmw: RTL and testbench

Load/store unit that sits directly upstream of the core's dual-port data BRAM and drives one of its ports. It accepts byte/half/word load and store requests from the pipeline MEM stage and hides the BRAM's one-cycle read latency. It converts sub-word stores into read-modify-write sequences, because the BRAM has a single whole-word write enable. It also flags misaligned accesses instead of issuing them.

---
 rtl/lsu_rmw_if.sv | 30 +++
 rtl/lsu_rmw.sv | 121 ++++++++++++
 tb/tb_lsu_rmw.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_if.sv
// Pipeline-request, response and BRAM-port signals of the load/store unit.
interface lsu_rmw_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 6
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [ADDRW-1:0] req_addr;
    logic [DATAW-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_err;
    logic [DATAW-1:0] resp_rdata;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_din;
    logic [DATAW-1:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/lsu_rmw.sv
// Byte/half/word load-store unit driving one BRAM port; sub-word stores become read-modify-write.
// Latency accept->resp: error 1, word store 2, load 3, sub-word store 4 cycles.
// One request in flight: req_ready only in IDLE; responses are a one-cycle pulse with no backpressure.
module lsu_rmw #(
    parameter int DATAW    = 32,
    parameter int ADDRW    = 6,
    parameter int WORD_LEN = 2
) (
    input  logic       clk,
    input  logic       rstn,
    lsu_rmw_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic                we;
        logic [1:0]          size;
        logic                uns;
        logic [WORD_LEN-1:0] lane;
    } req_t;

    state_t           state, state_nxt;
    req_t             in_req, cur;
    logic             in_err, err_q, accept;
    logic             mem_we_nxt, mem_we_q;
    logic [ADDRW-1:0] mem_addr_q;
    logic [DATAW-1:0] mem_din_q, rd_word, merged, load_ext;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    assign accept      = bus.req_valid && (state == S_IDLE);
    assign in_req.we   = bus.req_we;
    assign in_req.size = bus.req_size;
    assign in_req.uns  = bus.req_unsigned;
    assign in_req.lane = bus.req_addr[WORD_LEN-1:0];
    assign in_err      = (bus.req_size == 2'b11)
                      || (bus.req_size == 2'b01 && bus.req_addr[0])
                      || (bus.req_size == 2'b10 && (|bus.req_addr[WORD_LEN-1:0]));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_we_nxt = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                state_nxt  = in_err ? S_DONE : S_ISSUE;
                mem_we_nxt = !in_err && in_req.we && (in_req.size == 2'b10);
            end
            S_ISSUE: state_nxt = (cur.we && cur.size == 2'b10) ? S_DONE : S_WAIT;
            S_WAIT: begin
                state_nxt  = cur.we ? S_WRITE : S_DONE;
                mem_we_nxt = cur.we;
            end
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // mem_din still holds the right-aligned store data until WAIT, so it doubles as the merge source.
    always_comb begin
        merged = bus.mem_dout;
        if (cur.size == 2'b00)
            merged[{cur.lane, 3'b000} +: 8] = mem_din_q[7:0];
        else if (cur.size == 2'b01)
            merged[{cur.lane[WORD_LEN-1], 4'b0000} +: 16] = mem_din_q[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur        <= '0;
            err_q      <= 1'b0;
            rd_word    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_we_q <= mem_we_nxt;
            if (accept) begin
                cur   <= in_req;
                err_q <= in_err;
                if (!in_err) begin
                    mem_addr_q <= bus.req_addr;
                    mem_din_q  <= bus.req_wdata;
                end
            end
            if (state == S_WAIT) begin
                rd_word <= bus.mem_dout;
                if (cur.we) mem_din_q <= merged;
            end
        end
    end

    assign lane_b = rd_word[{cur.lane, 3'b000} +: 8];
    assign lane_h = rd_word[{cur.lane[WORD_LEN-1], 4'b0000} +: 16];

    always_comb begin
        case (cur.size)
            2'b00:   load_ext = {{(DATAW-8){!cur.uns && lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{(DATAW-16){!cur.uns && lane_h[15]}}, lane_h};
            default: load_ext = rd_word;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.resp_valid = (state == S_DONE);
        bus.resp_err   = (state == S_DONE) && err_q;
        bus.resp_rdata = '0;
        if (state == S_DONE && !err_q && !cur.we)
            bus.resp_rdata = load_ext;
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw with a BRAM model and a word-array reference model.
module tb_lsu_rmw;
    localparam int DATAW = 32;
    localparam int ADDRW = 6;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    lsu_rmw_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

    lsu_rmw #(.DATAW(DATAW), .ADDRW(ADDRW), .WORD_LEN(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] bram [16];
    logic [31:0] bram_dout;
    always @(posedge clk) begin
        if (bus.mem_we) bram[bus.mem_addr[5:2]] <= bus.mem_din;
        bram_dout <= bram[bus.mem_addr[5:2]];
    end
    assign bus.mem_dout = bram_dout;

    logic [31:0] ref_mem [16];
    int total = 0;
    int bad = 0;
    logic [31:0] last_rdata, last_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [5:0] addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [5:0] addr);
        logic [31:0] s;
        longint v;
        s = word >> (8 * (addr % 4));
        if (size == 0) begin
            v = s % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = s % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = word;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                                input logic [5:0] addr, input logic [31:0] wdata);
        logic [31:0] mask;
        int sh;
        sh = 8 * (addr % 4);
        if (size == 0)      mask = 32'hFF << sh;
        else if (size == 1) mask = 32'hFFFF << sh;
        else                mask = 32'hFFFF_FFFF;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [5:0] addr, input logic [31:0] wdata, input string tag);
        int resp_cyc, resp_cnt, exp_lat;
        logic [31:0] we_mask, exp_mask, din_seen, rdata_seen, addr1, prev_addr;
        logic [31:0] old, exp_word, exp_rdata;
        logic err_seen, exp_err;
        resp_cyc = 0; resp_cnt = 0; we_mask = 0; din_seen = 0; rdata_seen = 0;
        err_seen = 1'b0; addr1 = 0;
        wait_ready(tag);
        prev_addr         = 32'(bus.mem_addr);
        bus.req_valid     = 1'b1;
        bus.req_we        = we;
        bus.req_size      = size;
        bus.req_unsigned  = uns;
        bus.req_addr      = addr;
        bus.req_wdata     = wdata;
        @(posedge clk);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.req_valid = 1'b0;
                addr1 = 32'(bus.mem_addr);
            end
            if (bus.mem_we) begin
                we_mask  = we_mask | (32'd1 << n);
                din_seen = bus.mem_din;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin
                    resp_cyc   = n;
                    err_seen   = bus.resp_err;
                    rdata_seen = bus.resp_rdata;
                end
            end
        end

        exp_err   = model_err(size, addr);
        old       = ref_mem[addr / 4];
        exp_lat   = exp_err ? 1 : (we && size == 2) ? 2 : !we ? 3 : 4;
        exp_mask  = (exp_err || !we) ? 32'd0 : (size == 2) ? 32'd2 : 32'd8;
        exp_rdata = (!exp_err && !we) ? model_load(old, size, uns, addr) : 32'd0;
        exp_word  = (!exp_err && we) ? model_store(old, size, addr, wdata) : old;

        check({tag, " latency"}, 32'(resp_cyc), 32'(exp_lat));
        check({tag, " resp_count"}, 32'(resp_cnt), 32'd1);
        check({tag, " err"}, 32'(err_seen), 32'(exp_err));
        check({tag, " rdata"}, rdata_seen, exp_rdata);
        check({tag, " we_cycles"}, we_mask, exp_mask);
        if (exp_mask != 0) check({tag, " din"}, din_seen, exp_word);
        check({tag, " addr"}, addr1, exp_err ? prev_addr : 32'(addr));
        ref_mem[addr / 4] = exp_word;
        last_rdata = rdata_seen;
        last_din   = din_seen;
    endtask

    initial begin
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [5:0]  r_addr;
        logic [31:0] r_data;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #1 rstn = 1'b0;

        // Requests presented during reset must be ignored.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 6'h08; bus.req_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst mem_we", 32'(bus.mem_we), 32'd0);
            check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        bus.req_valid = 1'b0;
        rstn = 1'b1;
        #1;
        check("post_rst ready", 32'(bus.req_ready), 32'd1);
        check("post_rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check("post_rst mem_din", bus.mem_din, 32'd0);
        check("post_rst resp_err", 32'(bus.resp_err), 32'd0);
        check("post_rst resp_rdata", bus.resp_rdata, 32'd0);

        // Fill memory with word stores through the DUT.
        for (int i = 0; i < 16; i++) begin
            r_data = (i == 2) ? 32'hDEADBEEF : (i == 3) ? 32'h11223344 :
                     (i == 4) ? 32'h80FF7F01 : $urandom;
            do_req(1'b1, 2'b10, 1'b0, 6'(i * 4), r_data, "init sw");
        end
        do_req(1'b0, 2'b10, 1'b0, 6'h08, 32'd0, "lw 08");
        check("lw 08 value", last_rdata, 32'hDEADBEEF);

        do_req(1'b1, 2'b00, 1'b0, 6'h0D, 32'h0000_00AA, "sb 0D");
        check("sb 0D merge", last_din, 32'h1122AA44);
        do_req(1'b0, 2'b10, 1'b0, 6'h0C, 32'd0, "lw 0C");
        check("lw 0C value", last_rdata, 32'h1122AA44);

        do_req(1'b0, 2'b00, 1'b0, 6'h11, 32'd0, "lb 11");
        check("lb 11 value", last_rdata, 32'h0000007F);
        do_req(1'b0, 2'b00, 1'b0, 6'h12, 32'd0, "lb 12");
        check("lb 12 value", last_rdata, 32'hFFFFFFFF);
        do_req(1'b0, 2'b00, 1'b1, 6'h13, 32'd0, "lbu 13");
        check("lbu 13 value", last_rdata, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 6'h12, 32'd0, "lh 12");
        check("lh 12 value", last_rdata, 32'hFFFF80FF);
        do_req(1'b0, 2'b01, 1'b1, 6'h12, 32'd0, "lhu 12");
        check("lhu 12 value", last_rdata, 32'h000080FF);

        do_req(1'b0, 2'b10, 1'b0, 6'h06, 32'd0, "lw 06 misaligned");
        do_req(1'b1, 2'b01, 1'b0, 6'h03, 32'hCAFE_BABE, "sh 03 misaligned");
        do_req(1'b1, 2'b11, 1'b0, 6'h00, 32'hCAFE_BABE, "size11 00");
        do_req(1'b0, 2'b10, 1'b0, 6'h00, 32'd0, "lw 00 after errors");
        do_req(1'b0, 2'b10, 1'b0, 6'h04, 32'd0, "lw 04 after errors");

        // Reset in the WAIT cycle of a byte RMW must suppress the write and the response.
        wait_ready("rmw abort");
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 6'h0D; bus.req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort mem_we", 32'(bus.mem_we), 32'd0);
        check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort hold mem_we", 32'(bus.mem_we), 32'd0);
            check("abort hold resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        rstn = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 6'h0C, 32'd0, "lw 0C after abort");
        check("lw 0C after abort value", last_rdata, 32'h1122AA44);

        for (int i = 0; i < 300; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            r_addr = 6'($urandom_range(0, 63));
            r_data = $urandom;
            do_req(r_we, r_size, r_uns, r_addr, r_data, "rand");
        end
        for (int i = 0; i < 16; i++)
            do_req(1'b0, 2'b10, 1'b0, 6'(i * 4), 32'd0, "final lw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
